// File: rtl/instruction_fetch_queue_if.sv
// Handshake bundle between fetch, the instruction fetch queue and execute.
// The queue uses the slave modport; the surrounding pipeline uses master.
interface instruction_fetch_queue_if #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int ID_W  = 8
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic [PC_W-1:0]  in_pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_ir;
   logic [PC_W-1:0]  out_pc;
   logic [ID_W-1:0]  out_id;
   logic             out_illegal;
   logic [CNT_W-1:0] count;

   modport slave (
      input  in_valid, in_data, in_pc, flush, out_ready,
      output in_ready, out_valid, out_ir, out_pc, out_id, out_illegal, count
   );

   modport master (
      output in_valid, in_data, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_ir, out_pc, out_id, out_illegal, count
   );
endinterface

// File: rtl/instruction_fetch_queue.sv
// DEPTH-entry fetch queue that decodes RV32 words to instruction IDs at enqueue.
// Optional macro INSTRUCTION_FETCH_QUEUE_RV32M_EN enables decode of the M extension (IDs 10-17).
module instruction_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int ID_W  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   instruction_fetch_queue_if.slave      bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Map one instruction word to its 8-bit ID; 255 marks anything unsupported.
   function automatic logic [7:0] decode_id(input logic [31:0] w);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [7:0] id;
      op = w[6:0];
      f3 = w[14:12];
      f7 = w[31:25];
      id = 8'd255;
      case (op)
         7'b0110011: begin
            case (f7)
               7'b0000000: begin
                  case (f3)
                     3'b000:  id = 8'd0;
                     3'b001:  id = 8'd2;
                     3'b010:  id = 8'd3;
                     3'b011:  id = 8'd4;
                     3'b100:  id = 8'd5;
                     3'b101:  id = 8'd6;
                     3'b110:  id = 8'd8;
                     3'b111:  id = 8'd9;
                     default: id = 8'd255;
                  endcase
               end
               7'b0100000: begin
                  case (f3)
                     3'b000:  id = 8'd1;
                     3'b101:  id = 8'd7;
                     default: id = 8'd255;
                  endcase
               end
`ifdef INSTRUCTION_FETCH_QUEUE_RV32M_EN
               7'b0000001: id = 8'd10 + {5'd0, f3};
`else
               7'b0000001: id = 8'd255;
`endif
               default: id = 8'd255;
            endcase
         end
         7'b0010011: begin
            case (f3)
               3'b000:  id = 8'd18;
               3'b010:  id = 8'd19;
               3'b011:  id = 8'd20;
               3'b100:  id = 8'd21;
               3'b110:  id = 8'd22;
               3'b111:  id = 8'd23;
               3'b001:  id = (f7 == 7'b0000000) ? 8'd24 : 8'd255;
               3'b101: begin
                  case (f7)
                     7'b0000000: id = 8'd25;
                     7'b0100000: id = 8'd26;
                     default:    id = 8'd255;
                  endcase
               end
               default: id = 8'd255;
            endcase
         end
         7'b0000011: begin
            case (f3)
               3'b000:  id = 8'd27;
               3'b001:  id = 8'd28;
               3'b010:  id = 8'd29;
               3'b100:  id = 8'd30;
               3'b101:  id = 8'd31;
               default: id = 8'd255;
            endcase
         end
         7'b0100011: begin
            case (f3)
               3'b000:  id = 8'd32;
               3'b001:  id = 8'd33;
               3'b010:  id = 8'd34;
               default: id = 8'd255;
            endcase
         end
         7'b1100011: begin
            case (f3)
               3'b000:  id = 8'd35;
               3'b001:  id = 8'd36;
               3'b100:  id = 8'd37;
               3'b101:  id = 8'd38;
               3'b110:  id = 8'd39;
               3'b111:  id = 8'd40;
               default: id = 8'd255;
            endcase
         end
         7'b1101111: id = 8'd41;
         7'b1100111: id = (f3 == 3'b000) ? 8'd42 : 8'd255;
         7'b0110111: id = 8'd43;
         7'b0010111: id = 8'd44;
         default:    id = 8'd255;
      endcase
      return id;
   endfunction

   logic [31:0]      mem_ir_r [DEPTH];
   logic [PC_W-1:0]  mem_pc_r [DEPTH];
   logic [ID_W-1:0]  mem_id_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             in_ready_s;
   logic             out_valid_s;
   logic             push_s;
   logic             pop_s;
   logic [ID_W-1:0]  in_id_s;
   logic [ID_W-1:0]  head_id_s;

   // Handshake qualifiers; no full-bypass, so a full queue never accepts.
   always_comb begin
      in_ready_s  = (count_r != CNT_W'(DEPTH));
      out_valid_s = (count_r != {CNT_W{1'b0}});
      push_s      = bus.in_valid & in_ready_s;
      pop_s       = out_valid_s & bus.out_ready;
      in_id_s     = ID_W'(decode_id(bus.in_data));
      head_id_s   = mem_id_r[rd_ptr_r];
   end

   // Pointer and occupancy bookkeeping; flush outranks any push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (bus.flush) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk) begin
      if (push_s && !bus.flush) begin
         mem_ir_r[wr_ptr_r] <= bus.in_data;
         mem_pc_r[wr_ptr_r] <= bus.in_pc;
         mem_id_r[wr_ptr_r] <= in_id_s;
      end
   end

   // Head presentation, zeroed whenever nothing is valid.
   always_comb begin
      bus.in_ready  = in_ready_s;
      bus.out_valid = out_valid_s;
      bus.count     = count_r;
      if (out_valid_s) begin
         bus.out_ir      = mem_ir_r[rd_ptr_r];
         bus.out_pc      = mem_pc_r[rd_ptr_r];
         bus.out_id      = head_id_s;
         bus.out_illegal = (head_id_s == ID_W'(255));
      end else begin
         bus.out_ir      = 32'd0;
         bus.out_pc      = {PC_W{1'b0}};
         bus.out_id      = {ID_W{1'b0}};
         bus.out_illegal = 1'b0;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed-vector bench for instruction_fetch_queue (DEPTH 4, PC_W 32, ID_W 8).
module tb_instruction_fetch_queue;
   logic clk;
   logic rst_n;
   int   vec_cnt;
   int   err_cnt;

   instruction_fetch_queue_if #(.DEPTH(4), .PC_W(32), .ID_W(8)) bus ();

   instruction_fetch_queue #(.DEPTH(4), .PC_W(32), .ID_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w, input logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      bus.in_pc    = pc;
      step();
      bus.in_valid = 1'b0;
   endtask

   logic [31:0] fill_w  [4];
   logic [7:0]  fill_id [4];

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'd0;
      bus.in_pc     = 32'd0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      fill_w[0] = 32'h40315093; fill_id[0] = 8'd26;
      fill_w[1] = 32'h00013083; fill_id[1] = 8'd255;
      fill_w[2] = 32'hFFFFFFFF; fill_id[2] = 8'd255;
      fill_w[3] = 32'h023100B3;
`ifdef INSTRUCTION_FETCH_QUEUE_RV32M_EN
      fill_id[3] = 8'd10;
`else
      fill_id[3] = 8'd255;
`endif
      #2;
      check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check_val("rst_count",     64'(bus.count),     64'd0);
      check_val("rst_out_ir",    64'(bus.out_ir),    64'd0);
      check_val("rst_out_id",    64'(bus.out_id),    64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single ADD, one-cycle latency to head
      push_word(32'h003100B3, 32'h100);
      check_val("add_valid",   64'(bus.out_valid),   64'd1);
      check_val("add_id",      64'(bus.out_id),      64'd0);
      check_val("add_pc",      64'(bus.out_pc),      64'h100);
      check_val("add_ir",      64'(bus.out_ir),      64'h003100B3);
      check_val("add_count",   64'(bus.count),       64'd1);
      check_val("add_illegal", 64'(bus.out_illegal), 64'd0);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check_val("add_drain_count", 64'(bus.count), 64'd0);

      // Fill to DEPTH, then drain checking decode and illegal flag
      for (int i = 0; i < 4; i++) push_word(fill_w[i], 32'h200 + 32'(i) * 32'd4);
      check_val("full_in_ready", 64'(bus.in_ready), 64'd0);
      check_val("full_count",    64'(bus.count),    64'd4);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_val("drain_id",      64'(bus.out_id),      64'(fill_id[i]));
         check_val("drain_illegal", 64'(bus.out_illegal), 64'(fill_id[i] == 8'd255));
         check_val("drain_ir",      64'(bus.out_ir),      64'(fill_w[i]));
         step();
      end
      bus.out_ready = 1'b0;
      check_val("drain_empty", 64'(bus.out_valid), 64'd0);

      // Streaming push+pop across pointer wrap
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_data   = 32'h00A00093;
      for (int i = 0; i < 20; i++) begin
         bus.in_pc = 32'h1000 + 32'(i) * 32'd4;
         step();
         check_val("stream_count", 64'(bus.count),  64'd1);
         check_val("stream_pc",    64'(bus.out_pc), 64'(32'h1000 + 32'(i) * 32'd4));
      end
      bus.in_valid = 1'b0;
      step();
      bus.out_ready = 1'b0;
      check_val("stream_end_count", 64'(bus.count), 64'd0);

      // Flush with simultaneous push and pop
      for (int i = 0; i < 3; i++) push_word(32'h00000013, 32'h300 + 32'(i) * 32'd4);
      check_val("pre_flush_count", 64'(bus.count), 64'd3);
      bus.flush     = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_pc     = 32'h3F0;
      bus.out_ready = 1'b1;
      step();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check_val("flush_count", 64'(bus.count),     64'd0);
      check_val("flush_valid", 64'(bus.out_valid), 64'd0);
      push_word(32'h0000006F, 32'h500);
      check_val("post_flush_count", 64'(bus.count),  64'd1);
      check_val("post_flush_pc",    64'(bus.out_pc), 64'h500);
      check_val("post_flush_id",    64'(bus.out_id), 64'd41);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;

      // Full queue: pop only, offered word accepted on the next cycle
      for (int i = 0; i < 4; i++) push_word(32'h00000037, 32'h400 + 32'(i) * 32'd4);
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h00000017;
      bus.in_pc     = 32'h600;
      bus.out_ready = 1'b1;
      check_val("full_pop_in_ready", 64'(bus.in_ready), 64'd0);
      step();
      bus.out_ready = 1'b0;
      check_val("full_pop_count", 64'(bus.count),    64'd3);
      check_val("full_pop_head",  64'(bus.out_pc),   64'h404);
      check_val("full_pop_ready", 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      check_val("late_accept_count", 64'(bus.count), 64'd4);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_val("late_drain_pc", 64'(bus.out_pc), (i == 3) ? 64'h600 : 64'(32'h404 + 32'(i) * 32'd4));
         check_val("late_drain_id", 64'(bus.out_id), (i == 3) ? 64'd44 : 64'd43);
         step();
      end
      bus.out_ready = 1'b0;

      // Asynchronous reset between edges
      push_word(32'h00008067, 32'h700);
      push_word(32'h00008067, 32'h704);
      check_val("pre_rst_count", 64'(bus.count),  64'd2);
      check_val("jalr_id",       64'(bus.out_id), 64'd42);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_valid", 64'(bus.out_valid), 64'd0);
      check_val("async_rst_count", 64'(bus.count),     64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Parametrised successor to the single-entry fetch/decode register: a DEPTH-entry FIFO between instruction memory and the execute stage.
- Each accepted instruction word is decoded to the team's 8-bit instruction ID at enqueue.
- The raw word, its PC and its ID are buffered together and presented to execute with a valid/ready handshake.
- Adds flush (branch/jump redirect), occupancy reporting and explicit illegal-instruction flagging.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- PC_W, 32, width of the PC carried with each instruction.
- ID_W, 8, width of the decoded instruction ID; must be at least 8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch side presents a word.
- in_ready  output  1  queue can accept a word.
- in_data  input  32  raw RV32 instruction word.
- in_pc  input  PC_W  address of in_data.
- flush  input  1  discard all entries (redirect).
- out_valid  output  1  head entry available.
- out_ready  input  1  execute consumes the head.
- out_ir  output  32  head raw instruction.
- out_pc  output  PC_W  head PC.
- out_id  output  ID_W  head decoded ID.
- out_illegal  output  1  head ID equals 255.
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst_n low): read pointer, write pointer and count = 0; out_valid = 0; in_ready = 1.
  - Storage contents are don't-care.
  - out_ir, out_pc and out_id read as 0 while empty; they are forced to 0 when out_valid = 0.
- Push: occurs when in_valid & in_ready at a clock edge.
  - in_ready = (count != DEPTH). There is no full-bypass: a push while full is not possible, even if out_ready is high.
- Pop: occurs when out_valid & out_ready at a clock edge.
  - out_valid = (count != 0).
  - Head fields are driven combinationally from storage at the read pointer.
- Latency: a word pushed at edge N is visible at the head after edge N when the queue was empty. There is no same-cycle pass-through.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any non-empty, non-full occupancy.
- Pointers wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- flush: at the edge, pointers and count go to 0.
  - A simultaneous push is dropped and a simultaneous pop is ignored.
  - From the next cycle, out_valid = 0.
- Asserting rst_n low mid-operation empties the queue immediately, without waiting for a clock edge.
- Decode is purely combinational on in_data and is stored alongside the word. The ID is always fully assigned; nothing is retained from a previous word.
- ID encoding:
  - opcode 0110011, funct7 0000000: ADD 0, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, OR 8, AND 9, selected by funct3.
  - opcode 0110011, funct7 0100000: SUB 1 (funct3 000), SRA 7 (funct3 101).
  - opcode 0110011, funct7 0000001: MUL..REMU 10-17, selected by funct3 000-111.
  - opcode 0010011: ADDI 18, SLTI 19, SLTIU 20, XORI 21, ORI 22, ANDI 23.
  - opcode 0010011 shifts: SLLI 24 (funct7 0000000), SRLI 25 (funct7 0000000), SRAI 26 (funct7 0100000).
  - opcode 0000011: LB 27, LH 28, LW 29, LBU 30, LHU 31.
  - opcode 0100011: SB 32, SH 33, SW 34.
  - opcode 1100011: BEQ 35, BNE 36, BLT 37, BGE 38, BLTU 39, BGEU 40.
  - JAL 41; JALR 42 (funct3 000 only); LUI 43; AUIPC 44.
  - Any other opcode, funct3 or funct7 combination: 255.
- out_illegal is a registered-path compare of the stored ID against 255. An illegal word is queued normally; it is not dropped.

Optional Feature:
- Macro: INSTRUCTION_FETCH_QUEUE_RV32M_EN.
- Defined: funct7 0000001 R-type words decode to IDs 10-17.
- Undefined: those words decode to 255 and out_illegal = 1. All other behaviour is identical.

Test Plan:
- Reset then push 0x003100B3 (ADD) at pc 0x100 with out_ready = 0 → next cycle: out_valid = 1, out_id = 0, out_pc = 0x100, count = 1, out_illegal = 0.
- Push 0x40315093, 0x00013083, 0xFFFFFFFF, 0x023100B3 with out_ready = 0 → in_ready = 0 and count = 4 (DEPTH = 4).
  - Then drain: IDs 26, 255, 255, then 10 (or 255 with the macro undefined).
  - out_illegal is set for the 255 entries.
- Continuous push and pop with in_valid = out_ready = 1 for 20 cycles with incrementing PCs → count stays 1, PCs emerge in order across pointer wrap, none lost or duplicated.
- Fill to 3 entries, then assert flush together with in_valid = 1 and out_ready = 1 → next cycle count = 0, out_valid = 0; the next push appears alone at the head.
- Full queue with out_ready = 1 and in_valid = 1 in the same cycle → only the pop occurs, count goes 4 → 3, and the offered word is still presented and is accepted the following cycle.
- Drive rst_n low between clock edges with 2 entries queued → out_valid = 0 and count = 0 immediately, before the next rising edge.
